// File: rtl/serial_add8.sv
`default_nettype none
// ============================================================================
// Module   : serial_add8
// Brief    : Bit-serial adder that computes {co,S} = A + B + cin through one
//            full-adder cell, one bit per clock, with a start/busy/done handshake.
//            Optional macro SERIAL_ADD_OVF_EN adds a signed-overflow output (ovf).
// Revision : 1.0 - initial release
// ============================================================================
module serial_add8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             co,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int c_idx_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_c;
  logic [c_idx_w-1:0] r_idx;
  logic [WIDTH-1:0]   r_s;
  logic               r_co;
  logic               w_sum;
  logic               w_cout;
  logic               w_accept;
  logic               w_last;

  // Single full-adder cell working on the LSBs of the operand shift registers.
  assign w_sum    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cout   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_idx == c_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_ovf <= r_c ^ w_cout;
    end
  end
  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= 1'b0;
      r_idx <= '0;
      r_s   <= '0;
      r_co  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_c   <= cin;
      r_idx <= '0;
      r_s   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a        <= r_a >> 1;
      r_b        <= r_b >> 1;
      r_c        <= w_cout;
      r_s[r_idx] <= w_sum;
      if (w_last) begin
        r_co  <= w_cout;
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign S    = r_s;
  assign co   = r_co;
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_add8.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add8
// Brief    : Self-checking bench for serial_add8 against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add8;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic [W-1:0] S;
  logic         co;
  logic         busy;
  logic         done;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_add8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .S     (S),
    .co    (co),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; signed overflow from the signed sum range.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
    int unsigned t;
    t = int'(a) + int'(b) + int'(ci);
    return t[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci);
    int t;
    t = int'($signed(a)) + int'($signed(b)) + int'(ci);
    return (t > (2 ** (W - 1)) - 1) || (t < -(2 ** (W - 1)));
  endfunction

  // One operation. disturb=1 scrambles inputs during RUN and pulses start at RUN cycle 3.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input bit disturb);
    logic [W:0]   exp;
    logic [W-1:0] mask;
    int           lat;
    int           busy_cnt;
    exp = ref_sum(a, b, ci);
    @(negedge clk);
    A = a; B = b; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("s_cleared_on_start", 32'(S), 32'h0);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (lat > 0 && lat < W) begin
        mask = W'((1 << lat) - 1);
        check("partial_sum", 32'(S & mask), 32'(exp[W-1:0] & mask));
      end
      if (disturb) begin
        A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
        start = (lat == 3);
        if (lat == 3) begin A = 8'hFF; B = 8'hFF; end
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_latency", 32'(lat), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("sum", 32'(S), 32'(exp[W-1:0]));
    check("carry_out", 32'(co), 32'(exp[W]));
`ifdef SERIAL_ADD_OVF_EN
    check("overflow", 32'(ovf), 32'(ref_ovf(a, b, ci)));
`endif
    @(negedge clk);
    check("done_single_cycle", 32'(done), 32'h0);
    check("sum_held", {23'h0, co, S}, {23'h0, exp});
  endtask

  logic [W-1:0] vec_a [6] = '{8'h3C, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h10};
  logic [W-1:0] vec_b [6] = '{8'h55, 8'h01, 8'hFF, 8'h01, 8'h80, 8'h20};
  logic         vec_c [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};

  initial begin
    int n_done;
    int prev;
    bit was_done;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_sum", {23'h0, co, S}, 32'h0);
`ifdef SERIAL_ADD_OVF_EN
    check("reset_ovf", 32'(ovf), 32'h0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op(vec_a[i], vec_b[i], vec_c[i], 1'b0);

    // Start and operand changes during RUN must not disturb the result.
    run_op(8'h12, 8'h34, 1'b0, 1'b1);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("no_extra_done", 32'(n_done), 32'h0);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    A = 8'h55; B = 8'h33; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_sum", {23'h0, co, S}, 32'h0);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'h0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

    // Start held high: back-to-back results every WIDTH+1 cycles.
    @(negedge clk);
    A = 8'h0F; B = 8'h01; cin = 1'b0; start = 1'b1;
    n_done = 0; prev = -1; was_done = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 0 || was_done) check("b2b_run_cleared", 32'(S), 32'h0);
      was_done = done;
      if (done) begin
        n_done++;
        check("b2b_sum", {23'h0, co, S}, 32'h010);
        if (prev >= 0) check("b2b_period", 32'(cyc - prev), 32'(W + 1));
        prev = cyc;
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(n_done), 32'd3);
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
